// File: rtl/fft_io_pkg.sv
// Shared FFT frame I/O definitions: frame size, FSM states and the pair-reversal permutation.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package fft_io_pkg;

    localparam int N_WORDS = 64;
    localparam int IDX_W   = 6;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Pair-reversal permutation shared with the readout mux. Pair number p = k[5:1]
    // maps to (32 - p) mod 32, and the low bit stays in place. The map is an
    // involution, so the loader and the readout mux both use this one function.
    function automatic logic [IDX_W-1:0] perm_idx(input logic [IDX_W-1:0] k);
        logic [IDX_W-2:0] p_rev;
        p_rev = '0 - k[IDX_W-1:1];
        return {p_rev, k[0]};
    endfunction

endpackage

// File: rtl/fft_perm_idx.sv
// Maps a 6-bit stream index to its bank entry through the shared pair-reversal permutation.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module fft_perm_idx
    import fft_io_pkg::*;
(
    input  logic [IDX_W-1:0] k_i,
    output logic [IDX_W-1:0] idx_o
);

    assign idx_o = perm_idx(k_i);

endmodule

// File: rtl/frame_loader64.sv
// Loads a 64-word stream into a register bank in pair-reversed order and holds the frame until it is acked.
// Latency: an accepted word is visible on bank one cycle later. frame_valid rises after word 63 is accepted.
// Backpressure: in_ready is low while a complete frame is held. It comes from registered state only.
module frame_loader64
    import fft_io_pkg::*;
#(
    parameter int DATA_LENGTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_LENGTH-1:0]         in_data,
    input  logic                           in_valid,
    input  logic                           in_sof,
    output logic                           in_ready,
    output logic [N_WORDS*DATA_LENGTH-1:0] bank,
    output logic                           frame_valid,
    input  logic                           frame_ack,
    output logic                           sof_err
);

    localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_WORDS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic                    sof_err_q, sof_err_d;
    logic [DATA_LENGTH-1:0]  bank_q [N_WORDS];

    logic                    accept;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        wr_entry;

    assign in_ready    = (state_q == FILL);
    assign frame_valid = (state_q == FULL);
    assign sof_err     = sof_err_q;
    assign accept      = in_valid && in_ready;

    // An SOF word always takes stream index 0, whatever the counter holds.
    assign wr_idx = in_sof ? '0 : wr_cnt_q;

    fft_perm_idx u_perm (
        .k_i   (wr_idx),
        .idx_o (wr_entry)
    );

    // Next state: count accepted words, resync on SOF, and hold a full frame until it is acked.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        sof_err_d = 1'b0;
        if (accept) begin
            if (in_sof) begin
                // A resync on the last index takes priority over frame completion.
                wr_cnt_d  = CNT_ONE;
                sof_err_d = (wr_cnt_q != '0);
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
                if (wr_cnt_q == CNT_LAST) begin
                    state_d = FULL;
                end
            end
        end else if ((state_q == FULL) && frame_ack) begin
            state_d = FILL;
        end
    end

    // Control registers: FSM state, write counter and the registered SOF error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            sof_err_q <= sof_err_d;
        end
    end

    // Bank storage: only the decoded entry is written. Partial frames are left in place on resync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < N_WORDS; e++) begin
                bank_q[e] <= '0;
            end
        end else if (accept) begin
            bank_q[wr_entry] <= in_data;
        end
    end

    for (genvar e = 0; e < N_WORDS; e++) begin : g_bank
        assign bank[e*DATA_LENGTH +: DATA_LENGTH] = bank_q[e];
    end

endmodule

// File: tb/tb_frame_loader64.sv
module tb_frame_loader64;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_sof;
    logic           in_ready;
    logic [64*W-1:0] bank;
    logic           frame_valid;
    logic           frame_ack;
    logic           sof_err;

    int total = 0;
    int bad   = 0;

    // Reference model: per-entry contents, stream position, held-frame flag, expected error pulse.
    logic [W-1:0] mb [64];
    int           mk;
    bit           mfull;
    bit           merr;

    always #5 clk = ~clk;

    frame_loader64 #(.DATA_LENGTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .bank        (bank),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .sof_err     (sof_err)
    );

    // Stream index k lands in entry 2*((32 - k/2) mod 32) + (k mod 2).
    function automatic int ent(input int k);
        return (((32 - k / 2) % 32) * 2) + (k % 2);
    endfunction

    function automatic logic [64*W-1:0] mflat();
        logic [64*W-1:0] r;
        for (int e = 0; e < 64; e++) r[e*W +: W] = mb[e];
        return r;
    endfunction

    // Readout mux: output for select s is entry perm(s).
    function automatic logic [W-1:0] mux_out(input logic [64*W-1:0] b, input int sel);
        return b[ent(sel)*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [64*W-1:0] act, input logic [64*W-1:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < 64; e++) mb[e] = '0;
        mk    = 0;
        mfull = 0;
        merr  = 0;
    endtask

    // One clock cycle: drive inputs, update the model at the edge, then check every output.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic s, input logic a);
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        frame_ack = a;
        chk("in_ready", {511'd0, in_ready}, {511'd0, !mfull});
        @(posedge clk);
        merr = 0;
        if (v && !mfull) begin
            if (s) begin
                merr = (mk != 0);
                mk   = 0;
            end
            mb[ent(mk)] = d;
            mk++;
            if (mk == 64) begin
                mk    = 0;
                mfull = 1;
            end
        end else if (mfull && a) begin
            mfull = 0;
        end
        #1;
        chk("frame_valid", {511'd0, frame_valid}, {511'd0, mfull});
        chk("sof_err", {511'd0, sof_err}, {511'd0, merr});
        chk("bank", bank, mflat());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Assert reset away from the clock edge and check that it takes effect immediately.
    task automatic do_reset();
        in_valid  = 0;
        in_sof    = 0;
        frame_ack = 0;
        rst       = 1;
        model_reset();
        #1;
        chk("rst_bank", bank, '0);
        chk("rst_frame_valid", {511'd0, frame_valid}, '0);
        chk("rst_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});
        chk("rst_sof_err", {511'd0, sof_err}, '0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1;
        in_data   = '0;
        in_valid  = 0;
        in_sof    = 0;
        frame_ack = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Step 1: 10 random words, then reset mid-frame.
        for (int k = 0; k < 10; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset();

        // Step 2: a full frame with values 0..63, checked at the boundary entries.
        for (int k = 0; k < 64; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0);
        chk("full_after_63", {511'd0, frame_valid}, {511'd0, 1'b1});
        chk("entry62", {504'd0, bank[62*W +: W]}, {504'd0, 8'd2});
        chk("entry63", {504'd0, bank[63*W +: W]}, {504'd0, 8'd3});
        chk("entry32", {504'd0, bank[32*W +: W]}, {504'd0, 8'd32});
        chk("entry3",  {504'd0, bank[3*W +: W]},  {504'd0, 8'd63});
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Step 3: continuous k + 0x40, then sweep the readout mux.
        for (int k = 0; k < 64; k++) cycle(1'b1, 8'(k + 'h40), 1'b0, 1'b0);
        for (int s = 0; s < 64; s++)
            chk("readback", {504'd0, mux_out(bank, s)}, {504'd0, 8'(s + 'h40)});

        // Step 4: backpressure while FULL, then ack and take 0xAA as word 0.
        repeat (5) cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("bp_hold", {511'd0, in_ready}, '0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("bp_entry0", {504'd0, bank[7:0]}, {504'd0, 8'hAA});

        // Step 5: the rest of the frame with random gaps, stray SOFs on idle cycles and acks during FILL.
        for (int k = 1; k < 64; k++) begin
            repeat ($urandom_range(0, 2))
                cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Step 6: resync on the 20th word, then 63 more words complete the frame.
        cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        for (int k = 1; k < 19; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("resync_err", {511'd0, sof_err}, {511'd0, 1'b1});
        chk("resync_entry0", {504'd0, bank[7:0]}, {504'd0, 8'h55});
        for (int k = 1; k < 64; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("resync_full", {511'd0, frame_valid}, {511'd0, 1'b1});
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Step 7: SOF on stream index 63 restarts the frame instead of completing it.
        for (int k = 0; k < 63; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        chk("sof63_no_full", {511'd0, frame_valid}, '0);
        chk("sof63_err", {511'd0, sof_err}, {511'd0, 1'b1});
        chk("sof63_entry0", {504'd0, bank[7:0]}, {504'd0, 8'h99});
        idle(2);

        // Step 8: reset while FULL discards the frame.
        for (int k = 1; k < 64; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset();
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
